wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the in-order pipeline writeback stage and a long-latency unit (LU: divider, uncached load return). The LU delivers results through a valid/ready handshake. The block buffers LU results in a 2-entry FIFO and gives the pipeline priority. A starvation counter forces a one-cycle pipeline stall so that buffered LU results always drain. It also keeps a 32-bit scoreboard of registers whose LU result is still outstanding. It sits between the writeback stage outputs and the register file.

---
 rtl/rv_pkg.sv | 20 ++
 rtl/wb_fifo2.sv | 55 +++++
 rtl/wb_port_arbiter.sv | 111 +++++++++++
 tb/tb_wb_port_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared writeback types: register-file request bus and grant source encoding.
package rv_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned REGADDR_W = 5;
    localparam int unsigned NREGS     = 1 << REGADDR_W;

    typedef struct packed {
        logic                 we;
        logic [REGADDR_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_PIPE,
        GNT_LU
    } gnt_e;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry in-order FIFO of writeback requests; push when full and pop when empty are ignored.
module wb_fifo2
    import rv_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push_i,
    input  wb_req_t din_i,
    input  logic    pop_i,
    output wb_req_t dout_o,
    output logic    full_o,
    output logic    empty_o
);

    wb_req_t [1:0] mem_q, mem_d;
    logic          wr_ptr_q, wr_ptr_d;
    logic          rd_ptr_q, rd_ptr_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          push_ok, pop_ok;

    always_comb begin
        push_ok  = push_i && (cnt_q != 2'd2);
        pop_ok   = pop_i && (cnt_q != 2'd0);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = din_i;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + 2'(push_ok) - 2'(pop_ok);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);

endmodule

// File: rtl/wb_port_arbiter.sv
// Arbitrates the register-file write port between the pipeline writeback stage and buffered
// long-latency results, with a starvation stall and an outstanding-write scoreboard.
module wb_port_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pipe_we_i,
    input  logic [REGADDR_W-1:0] pipe_rd_i,
    input  logic [XLEN-1:0]      pipe_data_i,
    input  logic                 lu_valid_i,
    input  logic [REGADDR_W-1:0] lu_rd_i,
    input  logic [XLEN-1:0]      lu_data_i,
    output logic                 lu_ready_o,
    input  logic                 issue_i,
    input  logic [REGADDR_W-1:0] issue_rd_i,
    output logic [NREGS-1:0]     busy_o,
    output logic                 stall_o,
    output logic                 rf_we_o,
    output logic [REGADDR_W-1:0] rf_rd_o,
    output logic [XLEN-1:0]      rf_wdata_o
);

    localparam int unsigned CNT_W = 4;

    wb_req_t          pipe_req, lu_req, head, rf_req;
    logic             fifo_full, fifo_empty, fifo_push, fifo_pop;
    logic             pipe_eff;
    gnt_e             gnt;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             stall_q, stall_d;
    logic [NREGS-1:0] busy_q, busy_d;

    wb_fifo2 u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .din_i   (lu_req),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        pipe_req = '{we: pipe_we_i, rd: pipe_rd_i, data: pipe_data_i};
        lu_req   = '{we: 1'b1, rd: lu_rd_i, data: lu_data_i};

        // A stalled cycle masks the pipeline so the FIFO head is certain to win the port.
        pipe_eff = rst_n && pipe_req.we && (pipe_req.rd != '0) && !stall_q;

        gnt = GNT_NONE;
        if (pipe_eff) begin
            gnt = GNT_PIPE;
        end else if (!fifo_empty) begin
            gnt = GNT_LU;
        end

        rf_req = '0;
        unique case (gnt)
            GNT_PIPE: rf_req = pipe_req;
            GNT_LU: begin
                rf_req    = head;
                rf_req.we = head.we && (head.rd != '0);
            end
            default: rf_req = '0;
        endcase

        fifo_pop  = (gnt == GNT_LU);
        fifo_push = lu_valid_i && !fifo_full;

        if (fifo_empty || fifo_pop) begin
            wait_cnt_d = '0;
        end else begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
        stall_d = !fifo_empty && !fifo_pop && (wait_cnt_q == CNT_W'(STARVE_LIMIT - 1));

        // Issue is applied after the grant clear so a same-cycle set wins.
        busy_d = busy_q;
        if (fifo_pop) begin
            busy_d[head.rd] = 1'b0;
        end
        if (issue_i && (issue_rd_i != '0)) begin
            busy_d[issue_rd_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q <= '0;
            stall_q    <= 1'b0;
            busy_q     <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            stall_q    <= stall_d;
            busy_q     <= busy_d;
        end
    end

    assign lu_ready_o = !fifo_full;
    assign stall_o    = stall_q;
    assign busy_o     = busy_q;
    assign rf_we_o    = rf_req.we;
    assign rf_rd_o    = rf_req.rd;
    assign rf_wdata_o = rf_req.data;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed scenarios plus randomized traffic, checked every cycle against a queue-based model.
module tb_wb_port_arbiter;

    localparam int unsigned LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we_i;
    logic [4:0]  pipe_rd_i;
    logic [31:0] pipe_data_i;
    logic        lu_valid_i;
    logic [4:0]  lu_rd_i;
    logic [31:0] lu_data_i;
    logic        lu_ready_o;
    logic        issue_i;
    logic [4:0]  issue_rd_i;
    logic [31:0] busy_o;
    logic        stall_o;
    logic        rf_we_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wdata_o;

    always #5 clk = ~clk;

    wb_port_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_we_i   (pipe_we_i),
        .pipe_rd_i   (pipe_rd_i),
        .pipe_data_i (pipe_data_i),
        .lu_valid_i  (lu_valid_i),
        .lu_rd_i     (lu_rd_i),
        .lu_data_i   (lu_data_i),
        .lu_ready_o  (lu_ready_o),
        .issue_i     (issue_i),
        .issue_rd_i  (issue_rd_i),
        .busy_o      (busy_o),
        .stall_o     (stall_o),
        .rf_we_o     (rf_we_o),
        .rf_rd_o     (rf_rd_o),
        .rf_wdata_o  (rf_wdata_o)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    // Reference state: buffered LU results, cycles the head has waited, pending stall, busy set.
    ent_t        mq[$];
    int          head_wait;
    bit          m_stall;
    logic [31:0] m_busy;
    bit          last_stall;
    bit          last_push;
    logic [4:0]  obs_lu[$];
    logic [4:0]  pending[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        head_wait = 0;
        m_stall   = 1'b0;
        m_busy    = '0;
    endtask

    task automatic tick();
        bit          pe, lu_g;
        int          sz0;
        ent_t        h, e;
        logic        exp_we;
        logic [4:0]  exp_rd;
        logic [31:0] exp_data;
        @(negedge clk);
        sz0  = mq.size();
        pe   = pipe_we_i && (pipe_rd_i != 5'd0) && !m_stall;
        lu_g = !pe && (sz0 > 0);
        if (sz0 > 0) h = mq[0];
        exp_we = 1'b0; exp_rd = '0; exp_data = '0;
        if (pe) begin
            exp_we = 1'b1; exp_rd = pipe_rd_i; exp_data = pipe_data_i;
        end else if (lu_g) begin
            exp_we = (h.rd != 5'd0); exp_rd = h.rd; exp_data = h.data;
        end
        chk("rf_we", 32'(rf_we_o), 32'(exp_we));
        if (exp_we) begin
            chk("rf_rd", 32'(rf_rd_o), 32'(exp_rd));
            chk("rf_wdata", rf_wdata_o, exp_data);
        end
        chk("lu_ready", 32'(lu_ready_o), 32'(sz0 < 2));
        chk("stall", 32'(stall_o), 32'(m_stall));
        chk("busy", busy_o, m_busy);
        if (rf_we_o && rf_rd_o >= 5'd8 && rf_rd_o <= 5'd10) obs_lu.push_back(rf_rd_o);

        last_stall = m_stall;
        last_push  = lu_valid_i && (sz0 < 2);
        if (lu_g) void'(mq.pop_front());
        if (last_push) begin
            e.rd = lu_rd_i; e.data = lu_data_i;
            mq.push_back(e);
        end
        m_stall   = (sz0 > 0) && !lu_g && (head_wait == int'(LIMIT) - 1);
        head_wait = (sz0 == 0 || lu_g) ? 0 : head_wait + 1;
        if (lu_g) m_busy[h.rd] = 1'b0;
        if (issue_i && issue_rd_i != 5'd0) m_busy[issue_rd_i] = 1'b1;
        m_busy[0] = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [4:0] exp_order [3];
        int         idx;
        bit         from_pend;
        logic [4:0] r;

        rst_n = 1'b0;
        pipe_we_i = 1'b0; pipe_rd_i = '0; pipe_data_i = '0;
        lu_valid_i = 1'b0; lu_rd_i = '0; lu_data_i = '0;
        issue_i = 1'b0; issue_rd_i = '0;
        model_reset();

        // Reset with live requests on both inputs
        repeat (2) @(posedge clk);
        #1;
        pipe_we_i = 1'b1; pipe_rd_i = 5'd4; pipe_data_i = 32'h1234_5678;
        lu_valid_i = 1'b1; lu_rd_i = 5'd6; lu_data_i = 32'hAAAA_5555;
        #1;
        chk("rst_rf_we", 32'(rf_we_o), 32'd0);
        chk("rst_ready", 32'(lu_ready_o), 32'd1);
        chk("rst_busy", busy_o, 32'd0);
        chk("rst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_rf_we2", 32'(rf_we_o), 32'd0);
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        rst_n = 1'b1;
        repeat (2) tick();

        // Idle-port LU write
        issue_i = 1'b1; issue_rd_i = 5'd5;
        tick();
        issue_i = 1'b0;
        chk("busy5_set", 32'(busy_o[5]), 32'd1);
        lu_valid_i = 1'b1; lu_rd_i = 5'd5; lu_data_i = 32'hDEAD_BEEF;
        #1;
        chk("no_bypass", 32'(rf_we_o), 32'd0);
        tick();
        lu_valid_i = 1'b0;
        #1;
        chk("idle_we", 32'(rf_we_o), 32'd1);
        chk("idle_rd", 32'(rf_rd_o), 32'd5);
        chk("idle_data", rf_wdata_o, 32'hDEAD_BEEF);
        tick();
        chk("busy5_clr", 32'(busy_o[5]), 32'd0);

        // Contention: x1..x6 from the pipeline while x7 waits
        issue_i = 1'b1; issue_rd_i = 5'd7;
        tick();
        issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_rd_i = 5'd7; lu_data_i = $urandom;
        tick();
        lu_valid_i = 1'b0;
        idx = 0;
        for (int c = 1; c <= 8; c++) begin
            pipe_we_i = (idx < 6); pipe_rd_i = 5'(idx + 1); pipe_data_i = $urandom;
            #1;
            if (c == 5) begin
                chk("cont_stall", 32'(stall_o), 32'd1);
                chk("cont_lu_we", 32'(rf_we_o), 32'd1);
                chk("cont_lu_rd", 32'(rf_rd_o), 32'd7);
            end else begin
                chk("cont_nostall", 32'(stall_o), 32'd0);
            end
            if (c == 6) chk("cont_held_rd", 32'(rf_rd_o), 32'd5);
            tick();
            if (!last_stall) idx++;
        end
        pipe_we_i = 1'b0;

        // Full FIFO under continuous pipeline writes
        for (int i = 8; i <= 10; i++) begin
            issue_i = 1'b1; issue_rd_i = 5'(i);
            tick();
        end
        issue_i = 1'b0;
        obs_lu.delete();
        idx = 8;
        for (int c = 0; c < 20; c++) begin
            pipe_we_i = 1'b1; pipe_rd_i = 5'(11 + c % 10); pipe_data_i = $urandom;
            lu_valid_i = (idx <= 10); lu_rd_i = 5'(idx); lu_data_i = $urandom;
            #1;
            if (c == 2) chk("full_ready0", 32'(lu_ready_o), 32'd0);
            if (c == 5) begin
                chk("pop_ready0", 32'(lu_ready_o), 32'd0);
                chk("pop_rd8", 32'(rf_rd_o), 32'd8);
            end
            if (c == 6) chk("ready_back", 32'(lu_ready_o), 32'd1);
            tick();
            if (last_push) idx++;
        end
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        repeat (4) tick();
        exp_order = '{5'd8, 5'd9, 5'd10};
        chk("order_n", 32'(obs_lu.size()), 32'd3);
        for (int i = 0; i < obs_lu.size() && i < 3; i++) chk("order", 32'(obs_lu[i]), 32'(exp_order[i]));

        // x0 filtering
        pipe_we_i = 1'b1; pipe_rd_i = 5'd11; lu_valid_i = 1'b1; lu_rd_i = 5'd0; lu_data_i = $urandom;
        tick();
        pipe_rd_i = 5'd12; lu_data_i = $urandom;
        tick();
        pipe_rd_i = 5'd0;
        #1;
        chk("x0_full", 32'(lu_ready_o), 32'd0);
        chk("x0_we_a", 32'(rf_we_o), 32'd0);
        tick();
        lu_valid_i = 1'b0;
        #1;
        chk("x0_recover", 32'(lu_ready_o), 32'd1);
        chk("x0_we_b", 32'(rf_we_o), 32'd0);
        tick();
        #1;
        chk("x0_we_c", 32'(rf_we_o), 32'd0);
        tick();
        pipe_we_i = 1'b0;

        // Scoreboard set/clear collision on x3
        issue_i = 1'b1; issue_rd_i = 5'd3;
        tick();
        issue_i = 1'b0;
        lu_valid_i = 1'b1; lu_rd_i = 5'd3; lu_data_i = $urandom;
        tick();
        lu_valid_i = 1'b0; issue_i = 1'b1; issue_rd_i = 5'd3;
        #1;
        chk("coll_grant", 32'(rf_rd_o), 32'd3);
        tick();
        issue_i = 1'b0;
        chk("coll_busy3", 32'(busy_o[3]), 32'd1);
        pending.delete();
        pending.push_back(5'd3);

        // Randomized legal traffic
        for (int c = 0; c < 1500; c++) begin
            r = 5'($urandom_range(1, 31));
            issue_i = ($urandom % 4 == 0) && !m_busy[r]; issue_rd_i = r;
            r = 5'($urandom_range(0, 31));
            pipe_we_i = ($urandom % 10 < 6) && !m_busy[r]; pipe_rd_i = r; pipe_data_i = $urandom;
            from_pend = 1'b0;
            lu_valid_i = 1'b0; lu_rd_i = 5'($urandom); lu_data_i = $urandom;
            if (pending.size() > 0 && $urandom % 2 == 0) begin
                lu_valid_i = 1'b1; lu_rd_i = pending[0]; from_pend = 1'b1;
            end else if ($urandom % 20 == 0) begin
                lu_valid_i = 1'b1; lu_rd_i = 5'd0;
            end
            assert (!(issue_i && m_busy[issue_rd_i]) && !(pipe_we_i && m_busy[pipe_rd_i])) else begin
                $display("FAIL stimulus_guard issued illegal upstream traffic");
                $fatal(1);
            end
            if (issue_i) pending.push_back(issue_rd_i);
            tick();
            if (last_push && from_pend) void'(pending.pop_front());
        end

        // Reset mid-operation with a buffered result
        issue_i = 1'b0;
        pipe_we_i = 1'b1; pipe_rd_i = 5'd11; lu_valid_i = 1'b1; lu_rd_i = 5'd0;
        tick();
        pipe_we_i = 1'b0; lu_valid_i = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("mrst_rf_we", 32'(rf_we_o), 32'd0);
        chk("mrst_ready", 32'(lu_ready_o), 32'd1);
        chk("mrst_busy", busy_o, 32'd0);
        chk("mrst_stall", 32'(stall_o), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        pending.delete();
        repeat (3) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
